// File: rtl/multi_pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// multi_pattern_detector_pkg
//
// Shared constants and helper functions for the multi-channel serial pattern
// detector.
//
//   DEFAULT_PATTERN_LEN / DEFAULT_NUM_PATTERNS / DEFAULT_COUNT_WIDTH
//                           : default geometry of the detector
//   DEFAULT_PATTERN_INIT    : reset patterns, channel k at [k*LEN +: LEN]
//                             (channel 0 = 101, channel 1 = 010)
//   sel_width(n)            : width of a channel select, max(1, clog2(n))
//   fill_width(len)         : width of a per-channel fill counter that must
//                             hold the value len-1
// -----------------------------------------------------------------------------
package multi_pattern_detector_pkg;

   localparam int DEFAULT_PATTERN_LEN  = 3;
   localparam int DEFAULT_NUM_PATTERNS = 2;
   localparam int DEFAULT_COUNT_WIDTH  = 8;

   localparam logic [DEFAULT_NUM_PATTERNS*DEFAULT_PATTERN_LEN-1:0]
      DEFAULT_PATTERN_INIT = 6'b010_101;

   // A select bus never collapses to zero width, even for a single channel.
   function automatic int sel_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // Fill counts 0 .. len-1 and saturates there.
   function automatic int fill_width(input int len);
      int w;
      w = $clog2(len);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/multi_pattern_detector_channel.sv
// -----------------------------------------------------------------------------
// pattern_channel
//
// One detector channel: programmable pattern register, warm-up fill counter,
// Mealy match compare and saturating match counter. The bit history is owned
// by the parent and shared by all channels.
//
// Ports
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   history      : previous PATTERN_LEN-1 accepted bits, newest at LSB
//   i, in_valid  : current serial bit and its qualifier
//   overlap      : 1 = matches may share bits, 0 = restart after a match
//   pat_we       : load pat_data into this channel (already decoded)
//   pat_data     : new pattern, MSB oldest bit
//   count_clr    : synchronous clear of the match counter
//   o            : combinational match flag for the current bit
//   count        : match counter
//   count_sat    : counter is all-ones
// -----------------------------------------------------------------------------
module pattern_channel
   import multi_pattern_detector_pkg::*;
#(
   parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
   parameter int                     COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
   parameter logic [PATTERN_LEN-1:0] INIT        = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PATTERN_LEN-2:0] history,
   input  logic                   i,
   input  logic                   in_valid,
   input  logic                   overlap,
   input  logic                   pat_we,
   input  logic [PATTERN_LEN-1:0] pat_data,
   input  logic                   count_clr,
   output logic                   o,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   count_sat
);

   localparam int                FILL_W    = fill_width(PATTERN_LEN);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN - 1);

   logic [PATTERN_LEN-1:0] pattern;
   logic [FILL_W-1:0]      fill;
   logic                   armed;
   logic                   hit;

   // A match needs PATTERN_LEN-1 accepted bits since the last restart so
   // that the whole window {history, i} belongs to this channel's run.
   assign armed = (fill == FILL_FULL);
   assign hit   = in_valid && armed && ({history, i} == pattern);
   assign o     = hit;

   assign count_sat = &count;

   // Pattern register: the compare above still sees the old value during
   // the write cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pattern <= INIT;
      end else if (pat_we) begin
         pattern <= pat_data;
      end
   end

   // Fill counter. A load restarts warm-up and takes priority; otherwise a
   // non-overlapping match discards its bits, and a plain accepted bit
   // advances until saturation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fill <= '0;
      end else if (pat_we) begin
         fill <= '0;
      end else if (in_valid) begin
         if (hit && !overlap) begin
            fill <= '0;
         end else if (!armed) begin
            fill <= fill + 1'b1;
         end
      end
   end

   // Match counter. Clear wins over a same-cycle match; at all-ones it holds.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (count_clr) begin
         count <= '0;
      end else if (hit && !count_sat) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/multi_pattern_detector.sv
// -----------------------------------------------------------------------------
// multi_pattern_detector
//
// Serial-bit Mealy pattern detector with NUM_PATTERNS independently
// programmable channels. The match flags are combinational on the current
// bit; all state updates on the rising clock edge.
//
// Parameters
//   PATTERN_LEN  : bits per pattern (>= 2)
//   NUM_PATTERNS : number of channels (>= 2)
//   COUNT_WIDTH  : width of each match counter
//   PATTERN_INIT : reset patterns, channel k at [k*PATTERN_LEN +: PATTERN_LEN]
//
// Ports
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   in_valid, i  : serial bit and its qualifier
//   overlap      : 1 = overlapping matches, 0 = non-overlapping
//   pat_we       : pattern write enable
//   pat_sel      : channel to write; out-of-range selects are ignored
//   pat_data     : new pattern, MSB oldest bit, LSB newest bit
//   count_clr    : synchronous clear of all counters
//   o            : per-channel combinational match flag
//   match_count  : packed per-channel counts, channel k at [k*COUNT_WIDTH +:]
//   count_sat    : per-channel counter-saturated flag
// -----------------------------------------------------------------------------
module multi_pattern_detector
   import multi_pattern_detector_pkg::*;
#(
   parameter int PATTERN_LEN  = DEFAULT_PATTERN_LEN,
   parameter int NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
   parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
   parameter logic [NUM_PATTERNS*PATTERN_LEN-1:0] PATTERN_INIT = DEFAULT_PATTERN_INIT,
   localparam int SEL_W = sel_width(NUM_PATTERNS)
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                in_valid,
   input  logic                                i,
   input  logic                                overlap,
   input  logic                                pat_we,
   input  logic [SEL_W-1:0]                    pat_sel,
   input  logic [PATTERN_LEN-1:0]              pat_data,
   input  logic                                count_clr,
   output logic [NUM_PATTERNS-1:0]             o,
   output logic [NUM_PATTERNS*COUNT_WIDTH-1:0] match_count,
   output logic [NUM_PATTERNS-1:0]             count_sat
);

   logic [PATTERN_LEN-2:0]  history;
   logic [PATTERN_LEN-1:0]  window;
   logic [NUM_PATTERNS-1:0] ch_we;

   // Shared bit history. Shifting through the full window keeps the
   // expression valid for PATTERN_LEN = 2, where history is a single bit.
   assign window = {history, i};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         history <= '0;
      end else if (in_valid) begin
         history <= window[PATTERN_LEN-2:0];
      end
   end

   // Write-strobe decode. A select that matches no channel index produces
   // no strobe, so out-of-range writes fall away naturally.
   always_comb begin
      ch_we = '0;
      for (int k = 0; k < NUM_PATTERNS; k++) begin
         ch_we[k] = pat_we && (pat_sel == SEL_W'(k));
      end
   end

   for (genvar k = 0; k < NUM_PATTERNS; k++) begin : g_ch
      pattern_channel #(
         .PATTERN_LEN (PATTERN_LEN),
         .COUNT_WIDTH (COUNT_WIDTH),
         .INIT        (PATTERN_INIT[k*PATTERN_LEN +: PATTERN_LEN])
      ) u_ch (
         .clock     (clock),
         .reset     (reset),
         .history   (history),
         .i         (i),
         .in_valid  (in_valid),
         .overlap   (overlap),
         .pat_we    (ch_we[k]),
         .pat_data  (pat_data),
         .count_clr (count_clr),
         .o         (o[k]),
         .count     (match_count[k*COUNT_WIDTH +: COUNT_WIDTH]),
         .count_sat (count_sat[k])
      );
   end

endmodule

// File: tb/tb_multi_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_pattern_detector
//
// Directed bench. dut_a uses the default geometry; dut_b has three channels
// (101 / 010 / 111) and 2-bit counters so that an out-of-range select and
// counter saturation can be exercised. Both share the serial inputs.
// -----------------------------------------------------------------------------
module tb_multi_pattern_detector;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic       i;
   logic       overlap;
   logic       count_clr;
   logic [2:0] pat_data;
   logic       pat_we_a;
   logic [0:0] pat_sel_a;
   logic       pat_we_b;
   logic [1:0] pat_sel_b;

   logic [1:0]  o_a;
   logic [15:0] cnt_a;
   logic [1:0]  sat_a;
   logic [2:0]  o_b;
   logic [5:0]  cnt_b;
   logic [2:0]  sat_b;

   int total = 0;
   int bad   = 0;

   multi_pattern_detector dut_a (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .i           (i),
      .overlap     (overlap),
      .pat_we      (pat_we_a),
      .pat_sel     (pat_sel_a),
      .pat_data    (pat_data),
      .count_clr   (count_clr),
      .o           (o_a),
      .match_count (cnt_a),
      .count_sat   (sat_a)
   );

   multi_pattern_detector #(
      .PATTERN_LEN  (3),
      .NUM_PATTERNS (3),
      .COUNT_WIDTH  (2),
      .PATTERN_INIT (9'b111_010_101)
   ) dut_b (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .i           (i),
      .overlap     (overlap),
      .pat_we      (pat_we_b),
      .pat_sel     (pat_sel_b),
      .pat_data    (pat_data),
      .count_clr   (count_clr),
      .o           (o_b),
      .match_count (cnt_b),
      .count_sat   (sat_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; o is sampled 2 units
   // later, well clear of the next edge.
   task automatic send_a(input logic v, input logic b, input logic [1:0] exp, input string tag);
      in_valid = v;
      i        = b;
      #2;
      chk(tag, 32'(o_a), 32'(exp));
      @(posedge clock);
      #1;
   endtask

   task automatic send_b(input logic v, input logic b, input logic [2:0] exp, input string tag);
      in_valid = v;
      i        = b;
      #2;
      chk(tag, 32'(o_b), 32'(exp));
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      reset    = 1'b0;
   endtask

   // Test stream 1,1,0,1,0,1,0,1,1 and the expected o per valid bit.
   logic       s1   [9] = '{1, 1, 0, 1, 0, 1, 0, 1, 1};
   logic [1:0] e_ov [9] = '{0, 0, 0, 1, 2, 1, 2, 1, 0};
   logic [1:0] e_no [9] = '{0, 0, 0, 1, 2, 0, 0, 1, 0};

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      i         = 1'b0;
      overlap   = 1'b1;
      count_clr = 1'b0;
      pat_data  = 3'b000;
      pat_we_a  = 1'b0;
      pat_sel_a = 1'b0;
      pat_we_b  = 1'b0;
      pat_sel_b = 2'd0;
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_o_a",   32'(o_a),   32'd0);
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_sat_a", 32'(sat_a), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);

      // Overlapping matches
      overlap = 1'b1;
      for (int n = 0; n < 9; n++) send_a(1'b1, s1[n], e_ov[n], $sformatf("ov_o%0d", n));
      in_valid = 1'b0;
      chk("ov_cnt0", 32'(cnt_a[7:0]),  32'd3);
      chk("ov_cnt1", 32'(cnt_a[15:8]), 32'd2);

      // Non-overlapping matches
      do_reset();
      overlap = 1'b0;
      for (int n = 0; n < 9; n++) send_a(1'b1, s1[n], e_no[n], $sformatf("no_o%0d", n));
      in_valid = 1'b0;
      chk("no_cnt0", 32'(cnt_a[7:0]),  32'd2);
      chk("no_cnt1", 32'(cnt_a[15:8]), 32'd1);

      // in_valid gaps with random data in between
      do_reset();
      overlap = 1'b1;
      for (int n = 0; n < 9; n++) begin
         send_a(1'b1, s1[n], e_ov[n], $sformatf("gap_o%0d", n));
         send_a(1'b0, 1'($urandom_range(0, 1)), 2'b00, $sformatf("gap_idle%0d", n));
      end
      chk("gap_cnt0", 32'(cnt_a[7:0]),  32'd3);
      chk("gap_cnt1", 32'(cnt_a[15:8]), 32'd2);

      // Reprogram channel 0 to 110 on the cycle that completes 101
      do_reset();
      overlap = 1'b1;
      send_a(1'b1, 1'b1, 2'b00, "rp_b0");
      send_a(1'b1, 1'b0, 2'b00, "rp_b1");
      pat_we_a  = 1'b1;
      pat_sel_a = 1'b0;
      pat_data  = 3'b110;
      send_a(1'b1, 1'b1, 2'b01, "rp_old");
      pat_we_a  = 1'b0;
      send_a(1'b1, 1'b1, 2'b00, "rp_w0");
      send_a(1'b1, 1'b1, 2'b00, "rp_w1");
      send_a(1'b1, 1'b0, 2'b01, "rp_new");
      in_valid = 1'b0;
      chk("rp_cnt0", 32'(cnt_a[7:0]), 32'd2);

      // Asynchronous reset mid-stream; channel 0 still holds 110 here
      send_a(1'b1, 1'b1, 2'b00, "ar_b0");
      send_a(1'b1, 1'b0, 2'b10, "ar_b1");
      send_a(1'b1, 1'b1, 2'b00, "ar_b2");
      in_valid = 1'b1;
      i        = 1'b0;
      #1;
      chk("ar_pre_o", 32'(o_a), 32'b10);
      reset = 1'b1;
      #1;
      chk("ar_o",    32'(o_a),   32'd0);
      chk("ar_cnt",  32'(cnt_a), 32'd0);
      chk("ar_cntb", 32'(cnt_b), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      send_a(1'b1, 1'b0, 2'b00, "ar_r0");
      send_a(1'b1, 1'b1, 2'b00, "ar_r1");
      send_a(1'b1, 1'b0, 2'b10, "ar_r2");
      send_a(1'b1, 1'b1, 2'b01, "ar_r3");
      in_valid = 1'b0;

      // Out-of-range select on the three-channel instance
      do_reset();
      overlap   = 1'b1;
      pat_we_b  = 1'b1;
      pat_sel_b = 2'd3;
      pat_data  = 3'b000;
      send_b(1'b0, 1'b0, 3'b000, "sel3_wr");
      pat_we_b  = 1'b0;
      send_b(1'b1, 1'b1, 3'b000, "sel3_b0");
      send_b(1'b1, 1'b0, 3'b000, "sel3_b1");
      send_b(1'b1, 1'b1, 3'b001, "sel3_b2");
      send_b(1'b1, 1'b0, 3'b010, "sel3_b3");
      send_b(1'b1, 1'b0, 3'b000, "sel3_b4");
      send_b(1'b1, 1'b0, 3'b000, "sel3_b5");
      in_valid = 1'b0;

      // Counter saturation at COUNT_WIDTH = 2, then clear against a match
      do_reset();
      overlap = 1'b1;
      for (int n = 0; n < 11; n++) begin
         logic [2:0] e;
         e = (n < 2) ? 3'b000 : ((n % 2 == 0) ? 3'b001 : 3'b010);
         send_b(1'b1, 1'((n + 1) % 2), e, $sformatf("sat_o%0d", n));
         if (n == 4) begin
            chk("sat_cnt_2", 32'(cnt_b[1:0]), 32'd2);
            chk("sat_flag0", 32'(sat_b[0]),   32'd0);
         end
         if (n == 6) begin
            chk("sat_cnt_3", 32'(cnt_b[1:0]), 32'd3);
            chk("sat_flag1", 32'(sat_b[0]),   32'd1);
         end
      end
      chk("sat_hold0", 32'(cnt_b[1:0]), 32'd3);
      chk("sat_hold1", 32'(cnt_b[3:2]), 32'd3);
      send_b(1'b1, 1'b0, 3'b010, "clr_pre");
      count_clr = 1'b1;
      send_b(1'b1, 1'b1, 3'b001, "clr_hit");
      count_clr = 1'b0;
      in_valid  = 1'b0;
      chk("clr_cnt0", 32'(cnt_b[1:0]), 32'd0);
      chk("clr_cnt1", 32'(cnt_b[3:2]), 32'd0);
      chk("clr_sat",  32'(sat_b),      32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #50000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
